// File: rtl/player_controller.sv
// Player sprite controller: synchronized buttons, frame-rate movement with
// screen clamping, and a three-phase attack sequence counted in frames.
module player_controller #(
    parameter logic [9:0] X_INIT  = 10'd100,
    parameter logic [9:0] Y_INIT  = 10'd200,
    parameter logic [9:0] SPEED   = 10'd3,
    parameter logic [9:0] X_MAX   = 10'd576,
    parameter int         STARTUP = 5,
    parameter int         ACTIVE  = 2,
    parameter int         RECOVER = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [2:0] state,
    output logic       attacking,
    output logic [4:0] attack_frame
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        MOVE_L      = 3'd1,
        MOVE_R      = 3'd2,
        ATK_START   = 3'd4,
        ATK_ACTIVE  = 3'd5,
        ATK_RECOVER = 3'd6
    } state_t;

    localparam logic [5:0] END_START   = 6'(STARTUP + 1);
    localparam logic [5:0] END_ACTIVE  = 6'(STARTUP + ACTIVE + 1);
    localparam logic [5:0] END_RECOVER = 6'(STARTUP + ACTIVE + RECOVER + 1);

    state_t     st, st_nxt;
    logic [9:0] x_nxt;
    logic [4:0] af_nxt;
    logic [2:0] sync1, sync2;   // {attack, right, left}
    logic       atk_prev;
    logic       left, right, atk_req;
    logic [5:0] af_inc;
    logic [10:0] x_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {btn_attack, btn_right, btn_left};
            sync2 <= sync1;
        end
    end

    // Edge detection is per frame, so the previous level is sampled only on ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            atk_prev <= 1'b0;
        else if (frame_tick)
            atk_prev <= sync2[2];
    end

    assign left    = sync2[0];
    assign right   = sync2[1];
    assign atk_req = sync2[2] & ~atk_prev;
    assign af_inc  = {1'b0, attack_frame} + 6'd1;
    assign x_sum   = {1'b0, x_pos} + {1'b0, SPEED};

    always_comb begin
        st_nxt = st;
        x_nxt  = x_pos;
        af_nxt = attack_frame;
        case (st)
            IDLE, MOVE_L, MOVE_R: begin
                if (atk_req) begin
                    st_nxt = ATK_START;
                    af_nxt = 5'd1;
                end else if (left && !right) begin
                    st_nxt = MOVE_L;
                    x_nxt  = (x_pos < SPEED) ? 10'd0 : x_pos - SPEED;
                end else if (right && !left) begin
                    st_nxt = MOVE_R;
                    x_nxt  = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[9:0];
                end else begin
                    st_nxt = IDLE;
                end
            end
            ATK_START: begin
                af_nxt = af_inc[4:0];
                if (af_inc == END_START) st_nxt = ATK_ACTIVE;
            end
            ATK_ACTIVE: begin
                af_nxt = af_inc[4:0];
                if (af_inc == END_ACTIVE) st_nxt = ATK_RECOVER;
            end
            ATK_RECOVER: begin
                if (af_inc == END_RECOVER) begin
                    st_nxt = IDLE;
                    af_nxt = 5'd0;
                end else begin
                    af_nxt = af_inc[4:0];
                end
            end
            default: begin
                st_nxt = IDLE;
                af_nxt = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= IDLE;
            x_pos        <= X_INIT;
            attack_frame <= 5'd0;
        end else if (frame_tick) begin
            st           <= st_nxt;
            x_pos        <= x_nxt;
            attack_frame <= af_nxt;
        end
    end

    assign state     = st;
    assign attacking = (st == ATK_START) || (st == ATK_ACTIVE) || (st == ATK_RECOVER);
    assign y_pos     = Y_INIT;

endmodule

// File: tb/tb_player_controller.sv
// Bench for player_controller: frame-level behavioural model compared every
// cycle, plus directed literal expectations for the key scenarios.
module tb_player_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       btn_left, btn_right, btn_attack;
    logic [9:0] x_pos, y_pos;
    logic [2:0] state;
    logic       attacking;
    logic [4:0] attack_frame;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // model: position, movement direction, frames into attack (0 = none)
    int m_x, m_mv, m_atk;
    bit m_prev;

    always #5 clk = ~clk;

    player_controller dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
        .x_pos(x_pos), .y_pos(y_pos), .state(state),
        .attacking(attacking), .attack_frame(attack_frame)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_state();
        if (m_atk >= 1 && m_atk <= 5)  return 4;
        if (m_atk >= 6 && m_atk <= 7)  return 5;
        if (m_atk >= 8 && m_atk <= 23) return 6;
        return m_mv;
    endfunction

    function automatic void model_reset();
        m_x = 100; m_mv = 0; m_atk = 0; m_prev = 1'b0;
    endfunction

    function automatic void model_tick(input bit l, input bit r, input bit a);
        bit req;
        req    = a && !m_prev;
        m_prev = a;
        if (m_atk > 0) begin
            m_atk++;
            if (m_atk > 23) m_atk = 0;
        end else if (req) begin
            m_atk = 1;
            m_mv  = 0;
        end else if (l && !r) begin
            m_mv = 1;
            m_x  = (m_x < 3) ? 0 : m_x - 3;
        end else if (r && !l) begin
            m_mv = 2;
            m_x  = (m_x + 3 > 576) ? 576 : m_x + 3;
        end else begin
            m_mv = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_x", 32'(x_pos), 32'(m_x));
            chk("cmp_y", 32'(y_pos), 32'd200);
            chk("cmp_state", 32'(state), 32'(m_state()));
            chk("cmp_attacking", 32'(attacking), 32'(m_atk > 0));
            chk("cmp_attack_frame", 32'(attack_frame), 32'(m_atk));
        end
    end

    // Buttons settle through the synchronizer before the one-clk tick pulse
    task automatic frame(input bit l, input bit r, input bit a);
        btn_left = l; btn_right = r; btn_attack = a;
        repeat (3) @(posedge clk);
        @(negedge clk) frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        model_tick(l, r, a);
    endtask

    int xs [10] = '{103, 106, 109, 112, 115, 118, 121, 124, 127, 130};
    int starts;

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_attack = 1'b0;
        model_reset();
        #23;
        chk("rst_x", 32'(x_pos), 32'd100);
        chk("rst_y", 32'(y_pos), 32'd200);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_attacking", 32'(attacking), 32'd0);
        chk("rst_af", 32'(attack_frame), 32'd0);
        cmp_en = 1'b1;
        @(negedge clk) rst_n = 1'b1;

        // right held 10 ticks
        for (int i = 0; i < 10; i++) begin
            frame(0, 1, 0);
            chk("right_x", 32'(x_pos), 32'(xs[i]));
            chk("right_state", 32'(state), 32'd2);
        end
        // right clamp at X_MAX
        repeat (148) frame(0, 1, 0);
        chk("right_574", 32'(x_pos), 32'd574);
        frame(0, 1, 0);
        chk("right_576", 32'(x_pos), 32'd576);
        frame(0, 1, 0);
        chk("right_hold_576", 32'(x_pos), 32'd576);
        // left down to zero
        repeat (192) frame(1, 0, 0);
        chk("left_0", 32'(x_pos), 32'd0);
        frame(1, 0, 0);
        chk("left_hold_0", 32'(x_pos), 32'd0);
        chk("left_state", 32'(state), 32'd1);

        // left clamp from x=1 (below SPEED)
        @(negedge clk) rst_n = 1'b0;
        #1 model_reset();
        @(negedge clk) rst_n = 1'b1;
        repeat (33) frame(1, 0, 0);
        chk("left_1", 32'(x_pos), 32'd1);
        frame(1, 0, 0);
        chk("left_clamp_0", 32'(x_pos), 32'd0);
        repeat (20) frame(0, 1, 0);
        chk("pos_60", 32'(x_pos), 32'd60);
        frame(0, 0, 0);
        chk("idle_state", 32'(state), 32'd0);

        // single attack press
        for (int i = 1; i <= 24; i++) begin
            frame(0, 0, i == 1);
            if (i == 1)  chk("atk1_state", 32'(state), 32'd4);
            if (i == 5)  chk("atk5_state", 32'(state), 32'd4);
            if (i == 6)  chk("atk6_state", 32'(state), 32'd5);
            if (i == 7)  chk("atk7_state", 32'(state), 32'd5);
            if (i == 8)  chk("atk8_state", 32'(state), 32'd6);
            if (i == 23) chk("atk23_state", 32'(state), 32'd6);
            if (i == 23) chk("atk23_attacking", 32'(attacking), 32'd1);
            if (i == 24) chk("atk24_state", 32'(state), 32'd0);
            if (i == 24) chk("atk24_af", 32'(attack_frame), 32'd0);
        end
        chk("atk_x_frozen", 32'(x_pos), 32'd60);

        // attack held 40 ticks: exactly one attack
        starts = 0;
        for (int i = 0; i < 40; i++) begin
            frame(0, 0, 1);
            if (state == 3'd4 && attack_frame == 5'd1) starts++;
        end
        chk("held_one_attack", 32'(starts), 32'd1);
        frame(0, 0, 0);
        chk("held_end_idle", 32'(state), 32'd0);

        // left+attack starts attack without moving; re-press at frame 10 ignored
        frame(1, 0, 1);
        chk("left_atk_state", 32'(state), 32'd4);
        chk("left_atk_x", 32'(x_pos), 32'd60);
        repeat (8) frame(1, 0, 0);
        frame(0, 0, 1);
        chk("repress_af10", 32'(attack_frame), 32'd10);
        chk("repress_state", 32'(state), 32'd6);
        repeat (13) frame(0, 1, 0);
        chk("repress_af23", 32'(attack_frame), 32'd23);
        chk("repress_x", 32'(x_pos), 32'd60);
        frame(0, 0, 0);
        chk("repress_end", 32'(state), 32'd0);

        // left+right together -> IDLE
        frame(1, 1, 0);
        chk("both_state", 32'(state), 32'd0);
        chk("both_x", 32'(x_pos), 32'd60);

        // async reset mid-attack at frame 6
        frame(0, 0, 1);
        repeat (5) frame(0, 0, 0);
        chk("pre_rst_af", 32'(attack_frame), 32'd6);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'd0);
        chk("async_x", 32'(x_pos), 32'd100);
        chk("async_af", 32'(attack_frame), 32'd0);
        chk("async_attacking", 32'(attacking), 32'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        frame(0, 0, 0);
        chk("post_rst_idle", 32'(state), 32'd0);
        frame(0, 1, 0);
        chk("post_rst_move", 32'(x_pos), 32'd103);
        frame(0, 0, 1);
        chk("post_rst_atk", 32'(state), 32'd4);
        repeat (3) @(negedge clk);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/player_controller.md
PLAYER_CONTROLLER -- requirements
Module: player_controller

Interface
REQ-001 Parameter X_INIT, default 10'd100: x_pos after reset.
REQ-002 Parameter Y_INIT, default 10'd200: constant y_pos.
REQ-003 Parameter SPEED, default 10'd3: pixels moved per frame.
REQ-004 Parameter X_MAX, default 10'd576: rightmost legal x_pos (640 minus 64-px body).
REQ-005 Parameters STARTUP / ACTIVE / RECOVER, defaults 5 / 2 / 16: attack phase lengths in frames.
REQ-006 clk  in  1  system pixel clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 frame_tick  in  1  one-clk pulse per video frame; all game-state updates occur only on it.
REQ-009 btn_left, btn_right, btn_attack  in  1 each  raw asynchronous active-high buttons.
REQ-010 x_pos  out  10  body top-left X.
REQ-011 y_pos  out  10  body top-left Y, always Y_INIT.
REQ-012 state  out  3  0 IDLE, 1 MOVE_L, 2 MOVE_R, 4 ATK_START, 5 ATK_ACTIVE, 6 ATK_RECOVER; 3 and 7 unused.
REQ-013 attacking  out  1  high when state is 4, 5 or 6.
REQ-014 attack_frame  out  5  frames elapsed in the current attack, 0 outside attacks.

Function
REQ-015 Each button passes a 2-flop synchronizer; only synchronized values are used.
REQ-016 An attack request is a synchronized btn_attack that is high at a frame_tick and was low at the previous frame_tick (per-frame edge); holding the button never retriggers.
REQ-017 All registered outputs change on the clk edge where frame_tick=1 and hold otherwise; latency tick-to-output is one clk.
REQ-018 In IDLE/MOVE_L/MOVE_R, priority at a tick: attack request -> ATK_START with attack_frame=1; else left-only -> MOVE_L; else right-only -> MOVE_R; else (none or both) -> IDLE.
REQ-019 The x move is applied on the same tick the MOVE state is entered or held: MOVE_L x_pos <= (x_pos < SPEED) ? 0 : x_pos-SPEED; MOVE_R x_pos <= (x_pos+SPEED > X_MAX) ? X_MAX : x_pos+SPEED; sum computed in 11 bits, no wrap.
REQ-020 During states 4-6 x_pos is frozen and direction buttons are ignored.
REQ-021 attack_frame increments by 1 on every tick while attacking.
REQ-022 ATK_START -> ATK_ACTIVE at the tick where attack_frame would become STARTUP+1.
REQ-023 ATK_ACTIVE -> ATK_RECOVER at the tick where attack_frame would become STARTUP+ACTIVE+1.
REQ-024 ATK_RECOVER -> IDLE at the tick where attack_frame would become STARTUP+ACTIVE+RECOVER+1; attack_frame <= 0 on that tick; the block is IDLE for at least one frame before a new attack.
REQ-025 Attack requests arriving during states 4-6 are discarded, not queued.
REQ-026 Unused state codes 3 or 7 recover to IDLE on the next tick, attack_frame <= 0.

Reset
REQ-027 While rst_n=0: state=IDLE, x_pos=X_INIT, y_pos=Y_INIT, attacking=0, attack_frame=0, synchronizers and edge register cleared, independent of clk.
REQ-028 Reset asserted mid-attack aborts immediately to reset values; after release the first tick behaves per REQ-018.

Verification
REQ-029 Reset, btn_right held 10 ticks -> state=2, x_pos 103,106,...,130 one clk after each tick.
REQ-030 x_pos=574, btn_right held -> 576 and stays 576; x_pos=2, btn_left held -> 0 and stays 0.
REQ-031 Single btn_attack press -> state 4 for attack_frame 1-5, 5 for 6-7, 6 for 8-23, IDLE with attack_frame=0 at tick 24; attacking high ticks 1-23; x_pos unchanged.
REQ-032 btn_attack held 40 ticks -> exactly one attack; btn_left+btn_attack together -> ATK_START, x_pos unchanged; left+right together -> IDLE.
REQ-033 Second press at attack_frame=10 -> ignored, attack ends at tick 24 as normal.
REQ-034 rst_n pulsed low at attack_frame=6 between ticks -> outputs return to reset values immediately without a clk edge.
